// File: rtl/plant_model_pkg.sv
// Shared types and constants for the plant emulator.
// Build option: define PLANT_DISTURBANCE_EN to add the signed output disturbance port.
package plant_pkg;

    localparam int DATA_W    = 8;
    localparam int FRAC_W    = 8;
    localparam int MAX_DELAY = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FILTER = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/plant_model_delay_line.sv
// Dead-time delay line: circular buffer of DELAY commands, read-before-write.
// DELAY = 0 collapses to a wire from din to dout.
module plant_delay_line
    import plant_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DELAY > 0) begin : g_buf
            logic [DATA_W-1:0] r_mem [DELAY];
            logic [3:0]        r_ptr;

            // Oldest entry sits at the write pointer; select it with a compare mux
            always_comb begin
                dout = '0;
                for (int i = 0; i < DELAY; i++) begin
                    if (r_ptr == 4'(i)) dout = r_mem[i];
                end
            end

            // Overwrite the slot just read and advance the pointer, wrapping at DELAY-1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= 4'd0;
                    for (int i = 0; i < DELAY; i++) r_mem[i] <= '0;
                end else if (shift) begin
                    for (int i = 0; i < DELAY; i++) begin
                        if (r_ptr == 4'(i)) r_mem[i] <= din;
                    end
                    r_ptr <= (r_ptr == 4'(DELAY - 1)) ? 4'd0 : r_ptr + 4'd1;
                end
            end
        end else begin : g_bypass
            logic w_unused;
            assign w_unused = clk ^ rst_n ^ shift;
            assign dout     = din;
        end
    endgenerate

endmodule

// File: rtl/plant_model.sv
// Discrete-time plant: dead time followed by a first-order low-pass, one update per tick.
// Build option: PLANT_DISTURBANCE_EN adds a signed disturbance summed (and clamped) at the output.
module plant_model
    import plant_pkg::*;
#(
    parameter int DELAY       = 2,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [7:0]  control_in,
`ifdef PLANT_DISTURBANCE_EN
    input  logic [7:0]  disturbance,
`endif
    output logic [7:0]  feedback,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_cmd;
    logic [DATA_W-1:0]   r_ud;
    logic [15:0]         r_y;
    logic [DATA_W-1:0]   r_fb;
    logic                r_valid;
    logic                r_busy;
    logic                r_ovr;

    logic [DATA_W-1:0]   w_dout;
    logic                w_shift;
    logic signed [17:0]  w_diff;
    logic signed [17:0]  w_step;
    logic [17:0]         w_ysum;
    logic [1:0]          w_unused_hi;
    logic [DATA_W-1:0]   w_out;

    assign w_shift = (r_state == LOAD);

    plant_delay_line #(.DELAY(DELAY)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (w_shift),
        .din   (r_cmd),
        .dout  (w_dout)
    );

    // Filter step in 18-bit signed; arithmetic shift floors toward -inf.
    // The true sum stays within 0..0xFF00, so the top two bits are always zero.
    assign w_diff      = $signed({2'b00, r_ud, {FRAC_W{1'b0}}}) - $signed({2'b00, r_y});
    assign w_step      = w_diff >>> ALPHA_SHIFT;
    assign w_ysum      = {2'b00, r_y} + w_step;
    assign w_unused_hi = w_ysum[17:16];

`ifdef PLANT_DISTURBANCE_EN
    logic signed [9:0] w_dsum;
    assign w_dsum = $signed({2'b00, r_y[15:8]}) + $signed({{2{disturbance[7]}}, disturbance});
    // Clamp the disturbed measurement into the unsigned 8-bit range
    always_comb begin
        w_out = w_dsum[7:0];
        if (w_dsum[9])      w_out = 8'd0;
        else if (w_dsum[8]) w_out = 8'd255;
    end
`else
    assign w_out = r_y[15:8];
`endif

    // Sequencer: IDLE -> LOAD -> FILTER -> OUTPUT; ticks arriving outside IDLE are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_ud    <= '0;
            r_y     <= '0;
            r_fb    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_tick) begin
                        r_cmd   <= control_in;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_ud    <= w_dout;
                    r_state <= FILTER;
                end
                FILTER: begin
                    r_y     <= w_ysum[15:0];
                    r_state <= OUTPUT;
                end
                OUTPUT: begin
                    r_fb    <= w_out;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
            if (sample_tick && (r_state != IDLE)) r_ovr <= 1'b1;
        end
    end

    assign feedback = r_fb;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign overrun  = r_ovr;

endmodule

// File: tb/tb_plant_model.sv
// Bench for plant_model: three parameterisations driven from one tick stream,
// checked against a sample-level reference model and against fixed vectors.
module tb_plant_model;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] ctl [3];
    logic [7:0] fb  [3];
    logic       v   [3];
    logic       b   [3];
    logic       o   [3];
`ifdef PLANT_DISTURBANCE_EN
    logic [7:0] dist;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    int DLY [3] = '{0, 3, 2};
    int ASH [3] = '{2, 0, 2};
    int y_m [3];
    int cnt_m [3];
    int hist_m [3][64];

    plant_model #(.DELAY(0), .ALPHA_SHIFT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick), .control_in(ctl[0]),
`ifdef PLANT_DISTURBANCE_EN
        .disturbance(dist),
`endif
        .feedback(fb[0]), .valid(v[0]), .busy(b[0]), .overrun(o[0]));

    plant_model #(.DELAY(3), .ALPHA_SHIFT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick), .control_in(ctl[1]),
`ifdef PLANT_DISTURBANCE_EN
        .disturbance(dist),
`endif
        .feedback(fb[1]), .valid(v[1]), .busy(b[1]), .overrun(o[1]));

    plant_model #(.DELAY(2), .ALPHA_SHIFT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick), .control_in(ctl[2]),
`ifdef PLANT_DISTURBANCE_EN
        .disturbance(dist),
`endif
        .feedback(fb[2]), .valid(v[2]), .busy(b[2]), .overrun(o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d got=%0d want=%0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            y_m[i]   = 0;
            cnt_m[i] = 0;
        end
    endtask

    // One accepted sample: command from DELAY ticks ago, then y += floor((u*256 - y) / 2^A)
    task automatic model_tick(input int i, input int c, input int d, output int e);
        int ud, diff, s;
        hist_m[i][cnt_m[i] % 64] = c;
        if (DLY[i] == 0)              ud = c;
        else if (cnt_m[i] >= DLY[i])  ud = hist_m[i][(cnt_m[i] - DLY[i]) % 64];
        else                          ud = 0;
        cnt_m[i]++;
        diff = ud * 256 - y_m[i];
        y_m[i] = y_m[i] + (diff >>> ASH[i]);
        s = y_m[i] / 256 + d;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        e = s;
    endtask

    // Issue one tick and watch gap cycles: busy for 3, valid on the 4th with the new feedback
    task automatic run_tick(input int c0, input int c1, input int c2, input int d, input int gap);
        int e [3];
        tick = 1'b1;
        ctl[0] = 8'(c0);
        ctl[1] = 8'(c1);
        ctl[2] = 8'(c2);
`ifdef PLANT_DISTURBANCE_EN
        dist = 8'(d);
`endif
        for (int i = 0; i < 3; i++) model_tick(i, int'(ctl[i]), d, e[i]);
        for (int j = 0; j < gap; j++) begin
            step_clk();
            if (j == 0) tick = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("busy", i, int'(b[i]), int'(j < 3));
                chk("valid", i, int'(v[i]), int'(j == 3));
                if (j == 3) chk("fb", i, int'(fb[i]), e[i]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step_clk();
        step_clk();
        rst_n = 1'b1;
        model_reset();
        step_clk();
    endtask

    typedef struct {
        int c0;
        int c1;
        int c2;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int e;
        int nvalid;
        int d;

        // u0: step response to 200; u1: pure dead time of 3 samples
        tbl[0] = '{200, 10, 200,  50,  0};
        tbl[1] = '{200, 20, 200,  87,  0};
        tbl[2] = '{200, 30, 200, 115,  0};
        tbl[3] = '{200, 40, 200, 136, 10};
        tbl[4] = '{200, 50, 200, 152, 20};

        rst_n = 1'b0;
        tick  = 1'b0;
        for (int i = 0; i < 3; i++) ctl[i] = 8'd0;
`ifdef PLANT_DISTURBANCE_EN
        dist = 8'd0;
`endif
        model_reset();
        step_clk();
        step_clk();
        for (int i = 0; i < 3; i++) begin
            chk("rst_fb", i, int'(fb[i]), 0);
            chk("rst_valid", i, int'(v[i]), 0);
            chk("rst_busy", i, int'(b[i]), 0);
            chk("rst_ovr", i, int'(o[i]), 0);
        end
        rst_n = 1'b1;
        step_clk();

        // fixed vectors, one tick every 8 cycles
        for (int k = 0; k < 5; k++) begin
            run_tick(tbl[k].c0, tbl[k].c1, tbl[k].c2, 0, 8);
            chk("step_fb", 0, int'(fb[0]), tbl[k].e0);
            chk("dead_fb", 1, int'(fb[1]), tbl[k].e1);
        end
        for (int i = 0; i < 3; i++) chk("no_ovr", i, int'(o[i]), 0);

        // overrun: ticks on two consecutive edges; only the first is taken
        tick = 1'b1;
        for (int i = 0; i < 3; i++) ctl[i] = 8'd100;
        nvalid = 0;
        for (int i = 0; i < 3; i++) model_tick(i, 100, 0, e);
        for (int j = 0; j < 8; j++) begin
            step_clk();
            if (j == 0) for (int i = 0; i < 3; i++) ctl[i] = 8'd33;
            if (j == 1) tick = 1'b0;
            if (v[2]) nvalid++;
            chk("ovr_valid", 2, int'(v[2]), int'(j == 3));
            if (j == 3) chk("ovr_fb", 2, int'(fb[2]), e);
        end
        chk("ovr_npulse", 2, nvalid, 1);
        for (int i = 0; i < 3; i++) chk("ovr_flag", i, int'(o[i]), 1);
        // a follow-up sample exposes any extra pointer or y advance
        run_tick(60, 60, 60, 0, 8);
        for (int i = 0; i < 3; i++) chk("ovr_sticky", i, int'(o[i]), 1);

        // reset while in FILTER aborts the update and clears the buffers
        tick = 1'b1;
        for (int i = 0; i < 3; i++) ctl[i] = 8'd200;
        step_clk();
        tick = 1'b0;
        step_clk();
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_fb", i, int'(fb[i]), 0);
            chk("mid_valid", i, int'(v[i]), 0);
            chk("mid_busy", i, int'(b[i]), 0);
            chk("mid_ovr", i, int'(o[i]), 0);
        end
        model_reset();
        step_clk();
        step_clk();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step_clk();
            for (int i = 0; i < 3; i++) chk("post_valid", i, int'(v[i]), 0);
        end
        run_tick(77, 77, 77, 0, 8);
        chk("clr_fb", 2, int'(fb[2]), 0);

        // randomized samples with random spacing
        for (int k = 0; k < 60; k++) begin
            d = 0;
`ifdef PLANT_DISTURBANCE_EN
            d = int'($urandom_range(0, 255)) - 128;
`endif
            run_tick(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), d, int'($urandom_range(4, 9)));
        end

`ifdef PLANT_DISTURBANCE_EN
        do_reset();
        run_tick(200, 0, 0, -100, 8);
        chk("dist_lo", 0, int'(fb[0]), 0);
        do_reset();
        run_tick(200, 0, 0, 120, 8);
        chk("dist_mid", 0, int'(fb[0]), 170);
        do_reset();
        for (int k = 0; k < 3; k++) run_tick(0, 200, 0, 0, 8);
        run_tick(0, 200, 0, 100, 8);
        chk("dist_hi", 1, int'(fb[1]), 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plant_model.md
# plant_model

Synthesizable discrete-time plant emulator: the feedback end of the PID control loop. It consumes the 8-bit controller output on each sample tick and applies a programmable dead-time delay followed by a first-order low-pass response. It returns an 8-bit measured value to the controller's feedback input. Used on-chip for closed-loop self-test and in benches as the loop partner of the controller.

## Interface
- `DELAY`, default 2: dead time in samples, 0..15.
- `ALPHA_SHIFT`, default 2: filter time constant as a right shift, 0..7; 0 means pass-through.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_tick`  in  1  one-cycle strobe that starts one plant update.
- `control_in`  in  8  unsigned actuator command from the controller.
- `disturbance`  in  8  signed additive output disturbance; exists only when the `PLANT_DISTURBANCE_EN` macro is defined.
- `feedback`  out  8  unsigned plant output and measured value.
- `valid`  out  1  one-cycle pulse when `feedback` is updated.
- `busy`  out  1  high when the FSM is not in IDLE.
- `overrun`  out  1  sticky flag, set when a tick is dropped.

## Operation
- **FSM states and transitions:**
  - IDLE → LOAD on `sample_tick`.
  - LOAD → FILTER → OUTPUT → IDLE, unconditionally.
  - Illegal state encodings go to IDLE.
- **IDLE:** waits for a tick. `control_in` is captured on the tick edge.
- **LOAD (delay line):**
  - Circular buffer of `DELAY` 8-bit entries with a 4-bit write pointer that wraps at `DELAY`-1 → 0.
  - Read the slot at the pointer first, giving `u_d`. Then write the captured `control_in` to that slot and advance the pointer.
  - Result: `u_d` equals the command captured `DELAY` ticks earlier.
  - `DELAY`=0: no buffer; `u_d` = captured `control_in`.
- **FILTER (first-order response):**
  - State `y` is 16-bit unsigned 8.8 fixed point.
  - Update: `y <= y + ((u_d<<8) - y) >>> ALPHA_SHIFT`.
  - The difference is computed in 18-bit signed with an arithmetic shift; the result truncates toward −∞.
  - `y` stays within 0..0xFF00, so no saturation is needed.
- **OUTPUT:**
  - `feedback <= y[15:8]` (truncated, no rounding).
  - `valid` pulses for this cycle.
- **Tick while `busy`:** the tick is dropped and `overrun` is set. It does not change FSM state, the pointer, or `y`. `overrun` clears only on reset.
- **Tick on the same cycle OUTPUT returns to IDLE:** the tick is dropped, because the FSM is still in OUTPUT on that edge.

## Timing
- **Reset values:** `feedback`=0, `valid`=0, `busy`=0, `overrun`=0, `y`=0, all buffer entries=0, pointer=0, FSM=IDLE.
- **Latency:** tick sampled at edge k; LOAD at k+1, FILTER at k+2, OUTPUT at k+3. The new `feedback` and the `valid` pulse are visible after edge k+3.
- **Throughput:** one tick per 4 cycles maximum.
- **`busy`:** high from edge k through edge k+3, inclusive of the OUTPUT state.
- **Reset mid-operation:** aborts immediately. All state returns to reset values and no `valid` is emitted.
- `feedback` holds its value between updates.

## Configuration
- **With `PLANT_DISTURBANCE_EN` defined:**
  - The `disturbance` port exists.
  - OUTPUT computes the signed 10-bit sum `y[15:8] + disturbance`.
  - The sum is clamped to 0..255 and then drives `feedback`.
  - `disturbance` is sampled in the OUTPUT cycle.
  - `y` itself is never disturbed.
- **Without the macro:** the port is absent and `feedback = y[15:8]` directly.

## Structure
- **Shared package `plant_pkg`:**
  - FSM state enum (IDLE, LOAD, FILTER, OUTPUT; 2-bit).
  - `DATA_W`=8, `FRAC_W`=8, `MAX_DELAY`=15.
- **Sub-module `plant_delay_line`:**
  - Parameter: `DELAY`.
  - Ports: `clk`, `rst_n`, `shift` (LOAD strobe), `din`, `dout`.
  - Contains the buffer, the pointer, and the `DELAY`=0 bypass generate branch.
- The top level holds the FSM, the filter datapath, output registers and flags.

## Test plan
- **Step response:** `ALPHA_SHIFT`=2, `DELAY`=0, `control_in`=200, ticks every 8 cycles → `feedback` 50, 87, 115, … monotonically approaching 199.
- **Pure dead time:** `ALPHA_SHIFT`=0, `DELAY`=3, commands 10, 20, 30, 40, 50 on successive ticks → `feedback` 0, 0, 0, 10, 20.
- **Overrun:** ticks on two consecutive cycles → exactly one `valid` pulse 3 cycles after the first tick; `overrun`=1; the pointer advances once; `y` is updated once.
- **Latency/handshake:** a single tick at edge k → `busy` high for edges k..k+3, `valid` high only after edge k+3, no `valid` otherwise.
- **Reset mid-operation:** `rst_n` low during FILTER after three prior updates with 200 → immediately `feedback`=0, `valid`=0, `busy`=0. The next tick with `DELAY`=2 yields `u_d`=0, proving the buffer was cleared.
- **Disturbance** (`PLANT_DISTURBANCE_EN` defined), with `y[15:8]`=50:
  - `disturbance`=−100 → `feedback`=0.
  - `disturbance`=+120 (0x78) → 170.
  - `y[15:8]`=200 with `disturbance`=+100 → 255.
